round_controller: RTL

- Game sequencer for the two-player Halli Galli board.
- Takes decoded keypad events and the table-match flag from the judge logic.
- Sequences card flips: drives the random generator/card counter enable and the per-player card routing.
- Arbitrates bell presses between the two players and issues score award/penalty pulses to the score path until the deck is exhausted.

---
 rtl/halli_pkg.sv | 42 ++++
 rtl/resp_timer.sv | 33 +++
 rtl/round_controller.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/halli_pkg.sv
// Shared definitions for the Halli Galli round sequencer.
//   - keypad codes produced by the key decoder
//   - FSM state encoding (also exported on state_out for debug/LCD)
//   - default deck size
//   - a small key decode helper used by the controller
package halli_pkg;

   localparam logic [3:0] KEY_P1_FLIP = 4'd1;
   localparam logic [3:0] KEY_P2_FLIP = 4'd2;
   localparam logic [3:0] KEY_P1_BELL = 4'd3;
   localparam logic [3:0] KEY_P2_BELL = 4'd4;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] WAIT_FLIP = 3'd1;
   localparam logic [2:0] RESP      = 3'd2;
   localparam logic [2:0] JUDGE     = 3'd3;
   localparam logic [2:0] AWARD     = 3'd4;
   localparam logic [2:0] DONE      = 3'd5;

   localparam int DECK_SIZE_DEFAULT = 56;

   typedef struct packed {
      logic is_flip;
      logic is_bell;
      logic player;   // 0 = P1, 1 = P2
   } key_dec_t;

   // Codes outside 1..4 decode to neither flip nor bell.
   function automatic key_dec_t decode_key(input logic [3:0] code);
      key_dec_t d;
      d = '0;
      case (code)
         KEY_P1_FLIP: begin d.is_flip = 1'b1; d.player = 1'b0; end
         KEY_P2_FLIP: begin d.is_flip = 1'b1; d.player = 1'b1; end
         KEY_P1_BELL: begin d.is_bell = 1'b1; d.player = 1'b0; end
         KEY_P2_BELL: begin d.is_bell = 1'b1; d.player = 1'b1; end
         default:     d = '0;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/resp_timer.sv
// Loadable down-counter for the bell response window.
// Ports:
//   clk, rst   clock, async active-high reset (count -> 0)
//   load       load load_val (takes priority over en)
//   load_val   value to load
//   en         decrement by one; holds at zero
//   zero       count is zero
module resp_timer #(
   parameter int WIDTH = 26
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             en,
   output logic             zero
);

   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/round_controller.sv
// Round sequencer for the two-player Halli Galli board: deals cards on
// flip keys, opens a bell response window after each deal, arbitrates
// bell presses and issues award/penalty pulses until the deck runs out.
// Ports:
//   clk, rst      clock, async active-high reset
//   key_valid     one-cycle pulse, key_code valid
//   key_code      1/2 = P1/P2 flip, 3/4 = P1/P2 bell, others ignored
//   match         judge flag: shown cards satisfy the bell condition
//   deal_en       one-cycle pulse: draw a card
//   deal_player   owner of the dealt card (valid with deal_en)
//   turn          player whose flip is expected next
//   award_valid   one-cycle pulse to the score path
//   award_player  awarded player (valid with award_valid)
//   award_sign    1 = +1 (correct bell), 0 = -1 (false bell)
//   cards_left    cards not yet dealt
//   state_out     current FSM state
//   game_over     high in DONE
//
// state     | meaning
// ----------+------------------------------------------------------
// IDLE      | power-up, waiting for any key to start the game
// WAIT_FLIP | waiting for the flip key of `turn`; bells still judged
// RESP      | response window after a deal, timer running
// JUDGE     | sample match for the captured pusher
// AWARD     | award pulse out, table marked as claimed
// DONE      | deck exhausted, keys ignored until reset
module round_controller
   import halli_pkg::*;
#(
   parameter int RESP_CYCLES = 50_000_000,
   parameter int DECK_SIZE   = DECK_SIZE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       match,
   output logic       deal_en,
   output logic       deal_player,
   output logic       turn,
   output logic       award_valid,
   output logic       award_player,
   output logic       award_sign,
   output logic [5:0] cards_left,
   output logic [2:0] state_out,
   output logic       game_over
);

   // A one-cycle window still needs a 1-bit timer.
   localparam int TW = (RESP_CYCLES > 1) ? $clog2(RESP_CYCLES) : 1;
   localparam logic [TW-1:0] T_LOAD = TW'(RESP_CYCLES - 1);
   localparam logic [5:0] DECK_INIT = 6'(DECK_SIZE);

   logic [2:0] state, state_nxt;
   logic       claimed, claimed_nxt;
   logic       pusher, pusher_nxt;
   logic       turn_nxt;
   logic [5:0] cards_nxt;
   logic       deal_en_nxt, deal_player_nxt;
   logic       award_valid_nxt, award_player_nxt, award_sign_nxt;
   logic       tmr_load, tmr_en, tmr_zero;
   key_dec_t   kd;
   logic       flip_ok, bell_ok;

   resp_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (T_LOAD),
      .en       (tmr_en),
      .zero     (tmr_zero)
   );

   always_comb begin
      kd = decode_key(key_code);
      // cards_left guard keeps the counter saturated at zero.
      flip_ok = key_valid && kd.is_flip && (kd.player == turn) && (cards_left != '0);
      // claimed blocks a second award on a table that was already judged.
      bell_ok = key_valid && kd.is_bell && !claimed;

      state_nxt        = state;
      claimed_nxt      = claimed;
      pusher_nxt       = pusher;
      turn_nxt         = turn;
      cards_nxt        = cards_left;
      deal_en_nxt      = 1'b0;
      deal_player_nxt  = deal_player;
      award_valid_nxt  = 1'b0;
      award_player_nxt = award_player;
      award_sign_nxt   = award_sign;
      tmr_load         = 1'b0;
      tmr_en           = 1'b0;

      case (state)
         IDLE: begin
            if (key_valid && (kd.is_flip || kd.is_bell)) begin
               state_nxt = WAIT_FLIP;
            end
         end
         WAIT_FLIP: begin
            if (flip_ok) begin
               deal_en_nxt     = 1'b1;
               deal_player_nxt = turn;
               cards_nxt       = cards_left - 1'b1;
               turn_nxt        = ~turn;
               claimed_nxt     = 1'b0;
               tmr_load        = 1'b1;
               state_nxt       = RESP;
            end else if (bell_ok) begin
               pusher_nxt = kd.player;
               state_nxt  = JUDGE;
            end
         end
         RESP: begin
            tmr_en = 1'b1;
            // A bell on the last window cycle still wins over expiry.
            if (bell_ok) begin
               pusher_nxt = kd.player;
               state_nxt  = JUDGE;
            end else if (tmr_zero) begin
               state_nxt = (cards_left == '0) ? DONE : WAIT_FLIP;
            end
         end
         JUDGE: begin
            award_sign_nxt   = match;
            award_player_nxt = pusher;
            award_valid_nxt  = 1'b1;
            claimed_nxt      = 1'b1;
            state_nxt        = AWARD;
         end
         AWARD: begin
            state_nxt = (cards_left == '0) ? DONE : WAIT_FLIP;
         end
         DONE: begin
            state_nxt = DONE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         claimed      <= 1'b0;
         pusher       <= 1'b0;
         turn         <= 1'b0;
         cards_left   <= DECK_INIT;
         deal_en      <= 1'b0;
         deal_player  <= 1'b0;
         award_valid  <= 1'b0;
         award_player <= 1'b0;
         award_sign   <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         state        <= state_nxt;
         claimed      <= claimed_nxt;
         pusher       <= pusher_nxt;
         turn         <= turn_nxt;
         cards_left   <= cards_nxt;
         deal_en      <= deal_en_nxt;
         deal_player  <= deal_player_nxt;
         award_valid  <= award_valid_nxt;
         award_player <= award_player_nxt;
         award_sign   <= award_sign_nxt;
         game_over    <= (state_nxt == DONE);
      end
   end

   assign state_out = state;

endmodule
